// File: rtl/hyperbus_pkg.sv
// Shared types and default constants for the HyperBus read-strobe delay calibration.
package hyperbus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    REQ,
    WAIT,
    EVAL,
    PICK,
    DONE
  } calib_state_e;

  localparam int unsigned NumTapsC       = 4;
  localparam int unsigned DataWidthC     = 16;
  localparam int unsigned SamplesPerTapC = 4;
  localparam int unsigned SettleCyclesC  = 8;
  localparam int unsigned TimeoutCyclesC = 64;
  localparam int unsigned IdxW           = 6;

  localparam logic [15:0] PatternC      = 16'hA55A;
  localparam logic [31:0] DefaultDelayC = '0;

endpackage

// File: rtl/hyperbus_delay_calib_if.sv
// Training-read request and read-data return path between calibrator and read datapath.
interface hyperbus_delay_calib_if
  import hyperbus_pkg::*;
#(
  parameter int unsigned DataWidth = DataWidthC
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 rdata_valid;
  logic [DataWidth-1:0] rdata;

  modport master (output req_valid, input req_ready, rdata_valid, rdata);
  modport slave  (input req_valid, output req_ready, rdata_valid, rdata);
endinterface

// File: rtl/hyperbus_calib_window.sv
// Combinational longest-run-of-ones finder; ties resolve to the lowest start index.
module hyperbus_calib_window
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumTaps = NumTapsC
) (
  input  logic [NumTaps-1:0] win,
  output logic               found,
  output logic [IdxW-1:0]    start,
  output logic [IdxW-1:0]    len,
  output logic [IdxW-1:0]    centre
);

  logic [IdxW-1:0] run_start;
  logic [IdxW-1:0] run_len;

  always_comb begin
    found     = 1'b0;
    start     = '0;
    len       = '0;
    run_start = '0;
    run_len   = '0;
    for (int unsigned i = 0; i < NumTaps; i++) begin
      if (win[i]) begin
        if (run_len == '0) run_start = IdxW'(i);
        run_len = run_len + IdxW'(1);
        // Strictly greater keeps the earliest run on equal lengths.
        if (run_len > len) begin
          start = run_start;
          len   = run_len;
        end
      end else begin
        run_len = '0;
      end
    end
    found  = (len != '0);
    centre = start + ((len - IdxW'(1)) >> 1);
  end

endmodule

// File: rtl/hyperbus_delay_calib.sv
// Sweeps the RWDS delay tap, samples a training word per tap and programs the centre of the widest passing window.
module hyperbus_delay_calib
  import hyperbus_pkg::*;
#(
  parameter int unsigned          NumTaps       = NumTapsC,
  parameter int unsigned          DataWidth     = DataWidthC,
  parameter logic [DataWidth-1:0] Pattern       = DataWidth'(PatternC),
  parameter int unsigned          SamplesPerTap = SamplesPerTapC,
  parameter int unsigned          SettleCycles  = SettleCyclesC,
  parameter int unsigned          TimeoutCycles = TimeoutCyclesC,
  parameter logic [31:0]          DefaultDelay  = DefaultDelayC
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   fail_o,
  output logic [31:0]            delay_o,
  output logic [NumTaps-1:0]     win_o,
  hyperbus_delay_calib_if.master rd
);

  calib_state_e state_q, state_d;
  logic [4:0]   tap_q, tap_d;
  logic [7:0]   samp_q, samp_d;
  logic [15:0]  settle_q, settle_d;
  logic [15:0]  tmo_q, tmo_d;
  logic         pass_q, pass_d;
  logic         busy_d, done_d, fail_d, req_valid_d;
  logic [31:0]  delay_d;
  logic [NumTaps-1:0] win_d;

  logic            win_found;
  logic [IdxW-1:0] win_start, win_len, win_centre;
  logic            win_unused;

  hyperbus_calib_window #(.NumTaps(NumTaps)) u_window (
    .win    (win_o),
    .found  (win_found),
    .start  (win_start),
    .len    (win_len),
    .centre (win_centre)
  );

  assign win_unused = ^{win_start, win_len};

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    samp_d      = samp_q;
    settle_d    = settle_q;
    tmo_d       = tmo_q;
    pass_d      = pass_q;
    busy_d      = busy_o;
    done_d      = 1'b0;
    fail_d      = fail_o;
    req_valid_d = rd.req_valid;
    delay_d     = delay_o;
    win_d       = win_o;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = SETTLE;
          tap_d    = '0;
          delay_d  = '0;
          win_d    = '0;
          fail_d   = 1'b0;
          busy_d   = 1'b1;
          samp_d   = '0;
          settle_d = '0;
          pass_d   = 1'b1;
        end
      end
      SETTLE: begin
        if (settle_q == 16'(SettleCycles - 1)) begin
          state_d     = REQ;
          req_valid_d = 1'b1;
        end else begin
          settle_d = settle_q + 16'd1;
        end
      end
      REQ: begin
        if (rd.req_ready) begin
          state_d     = WAIT;
          req_valid_d = 1'b0;
          tmo_d       = '0;
        end
      end
      WAIT: begin
        if (rd.rdata_valid) begin
          if (rd.rdata != Pattern) pass_d = 1'b0;
          samp_d  = samp_q + 8'd1;
          state_d = EVAL;
        end else if (tmo_q == 16'(TimeoutCycles - 1)) begin
          pass_d  = 1'b0;
          samp_d  = samp_q + 8'd1;
          state_d = EVAL;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      EVAL: begin
        if (samp_q < 8'(SamplesPerTap)) begin
          state_d     = REQ;
          req_valid_d = 1'b1;
        end else begin
          for (int unsigned i = 0; i < NumTaps; i++) begin
            if (tap_q == 5'(i)) win_d[i] = pass_q;
          end
          if (tap_q < 5'(NumTaps - 1)) begin
            tap_d    = tap_q + 5'd1;
            delay_d  = 32'(tap_q) + 32'd1;
            settle_d = '0;
            samp_d   = '0;
            pass_d   = 1'b1;
            state_d  = SETTLE;
          end else begin
            state_d = PICK;
          end
        end
      end
      PICK: begin
        if (win_found) begin
          delay_d = 32'(win_centre);
        end else begin
          delay_d = DefaultDelay;
          fail_d  = 1'b1;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      tap_q        <= '0;
      samp_q       <= '0;
      settle_q     <= '0;
      tmo_q        <= '0;
      pass_q       <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      fail_o       <= 1'b0;
      rd.req_valid <= 1'b0;
      delay_o      <= DefaultDelay;
      win_o        <= '0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      samp_q       <= samp_d;
      settle_q     <= settle_d;
      tmo_q        <= tmo_d;
      pass_q       <= pass_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
      fail_o       <= fail_d;
      rd.req_valid <= req_valid_d;
      delay_o      <= delay_d;
      win_o        <= win_d;
    end
  end

endmodule

// File: doc/hyperbus_delay_calib.md
# hyperbus_delay_calib

Training controller that sweeps the read-strobe delay-line tap code, checks a known training word read back through the HyperBus read path at each tap, and programs the centre of the widest passing window. It sits in the PHY next to the RWDS delay line. It drives that line's `delay` input and issues training reads into the read datapath through a valid/ready request port. It runs after reset or on software request, then holds the chosen code until the next calibration.

## Interface
Parameters:
- `NumTaps`, 4 — number of delay codes swept, 0..NumTaps-1; must be ≤ 32.
- `DataWidth`, 16 — width of the training read word.
- `Pattern`, 16'hA55A — expected training word.
- `SamplesPerTap`, 4 — reads per tap; all must match for the tap to pass.
- `SettleCycles`, 8 — wait after each delay change before the first read.
- `TimeoutCycles`, 64 — maximum wait for read data per request.
- `DefaultDelay`, 0 — code used at reset and on calibration failure.

Ports:
- `clk_i` in 1 — single clock.
- `rst_ni` in 1 — synchronous, active-low reset.
- `start_i` in 1 — pulse that starts calibration; ignored while `busy_o`.
- `busy_o` out 1 — high from the cycle after an accepted start until the result is committed.
- `done_o` out 1 — one-cycle pulse when the result is committed.
- `fail_o` out 1 — sticky; 1 when the last calibration found no passing tap; cleared on accepted start.
- `delay_o` out 32 — registered tap code to the delay line.
- `win_o` out NumTaps — pass bitmap from the last sweep; bit i = tap i passed.
- `req_valid_o` out 1 — training-read request.
- `req_ready_i` in 1 — request accepted.
- `rdata_valid_i` in 1 — read word valid.
- `rdata_i` in DataWidth — read word.

## Operation
FSM states: IDLE, SETTLE, REQ, WAIT, EVAL, PICK, DONE.
- **IDLE:** on `start_i` go to SETTLE with:
  - tap = 0, `delay_o` = 0
  - `win_o` cleared, `fail_o` cleared, `busy_o` = 1
  - sample counter = 0, settle counter = 0
- **SETTLE:** count SettleCycles cycles, then go to REQ.
- **REQ:** assert `req_valid_o`, hold it until `req_ready_i`, then go to WAIT and clear the timeout counter.
- **WAIT:**
  - On `rdata_valid_i`: compare `rdata_i` to Pattern; a mismatch clears the tap's pass flag (the flag starts at 1 for each tap).
  - On timeout (counter reaches TimeoutCycles with no data): clear the pass flag.
  - After either event, go to EVAL.
  - `rdata_valid_i` outside WAIT is ignored.
- **EVAL:**
  - If fewer than SamplesPerTap samples are done, go to REQ.
  - Otherwise write the pass flag to `win_o[tap]`.
  - If tap < NumTaps-1: increment tap, set `delay_o` = tap, go to SETTLE.
  - Otherwise go to PICK.
  - A tap whose pass flag has already failed still completes all its samples; there is no early exit.
- **PICK:** scan `win_o` for the longest contiguous run of 1s.
  - On a length tie, the lowest start index wins.
  - Code = start + (len-1)/2, using integer division that truncates.
  - If no bit is set: `delay_o` = DefaultDelay and `fail_o` = 1.
  - Go to DONE.
- **DONE:** pulse `done_o`, drop `busy_o`, return to IDLE.
- **Reset** (`rst_ni` = 0 on a rising edge), from any state including mid-sweep:
  - state = IDLE, `delay_o` = DefaultDelay
  - `busy_o`, `done_o`, `fail_o`, `req_valid_o` = 0, `win_o` = 0
  - an outstanding read is abandoned.

## Timing
- Every output is registered; reset values are as listed above.
- `req_valid_o` is asserted exactly one cycle after SETTLE ends. It is never deasserted before the handshake, and it is never asserted while in WAIT (one outstanding request only).
- Cost per tap, assuming zero-wait ready and data one cycle after the handshake: 1 (tap update) + SettleCycles + SamplesPerTap × 3 cycles.
- PICK is a single cycle, using a combinational scan over NumTaps.
- `done_o` is asserted the cycle after PICK; `delay_o` is final in that same cycle.
- A `start_i` in the same cycle as `done_o` is ignored; a start is accepted from IDLE only.
- `delay_o` changes only in IDLE (on start), in EVAL, in PICK, and on reset.

## Structure
- Package `hyperbus_pkg` holds:
  - the `calib_state_e` enum
  - the DefaultDelay, Pattern and timing constants used by the PHY top.
- One natural sub-module: `hyperbus_calib_window`. It is a combinational longest-run finder over the `win_o` bitmap. It outputs `{found, start, len, centre}` and is unit-testable on its own.

## Test plan
- **All taps pass:** every read returns 16'hA55A, NumTaps = 4. Required: `win_o` = 4'b1111, `delay_o` = 1, `fail_o` = 0, exactly one `done_o` pulse.
- **Window in the middle:**
  - Setup: taps 0 and 3 get a corrupted read on sample 2.
  - Required: `win_o` = 4'b0110, `delay_o` = 1.
  - Sample counts checked: exactly 16 requests issued in total.
- **No response:** `rdata_valid_i` is never asserted. Required: each request times out after 64 cycles, `win_o` = 0, `fail_o` = 1, `delay_o` = DefaultDelay.
- **Backpressure:** `req_ready_i` is held low for 10 cycles per request. Required: `req_valid_o` stays high and stable throughout; the result is unchanged against the zero-wait run.
- **Reset mid-sweep:** assert `rst_ni` = 0 while in WAIT at tap 2.
  - Required: the next cycle shows IDLE, `delay_o` = DefaultDelay and `busy_o` = 0.
  - A late `rdata_valid_i` arriving after reset has no effect.
- **Tie and restart:**
  - Setup: with NumTaps = 8, bitmap 8'b1100_0011 yields `delay_o` = 0.
  - `start_i` while busy is ignored.
  - A new start clears `fail_o` and `win_o`.
